// File: rtl/alarm_trigger_pkg.sv
// Shared types and constants for the alarm trigger: FSM state encoding,
// wristwatch time field widths and a setting range check.
package alarm_trigger_pkg;

   localparam int unsigned HOUR_W      = 5;
   localparam int unsigned MIN_W       = 6;
   localparam int unsigned SEC_W       = 6;
   localparam int unsigned SEC_PER_MIN = 60;
   localparam int unsigned HOUR_MAX    = 23;
   localparam int unsigned MIN_MAX     = 59;

   typedef enum logic [2:0] {
      ST_DISARMED = 3'd0,
      ST_ARMED    = 3'd1,
      ST_RINGING  = 3'd2,
      ST_SNOOZE   = 3'd3,
      ST_LOCKOUT  = 3'd4
   } state_t;

   // An alarm setting outside the 24h clock face can never be reached.
   function automatic logic setting_valid(input logic [HOUR_W-1:0] hour,
                                          input logic [MIN_W-1:0]  minute);
      return (hour <= HOUR_W'(HOUR_MAX)) && (minute <= MIN_W'(MIN_MAX));
   endfunction

endpackage

// File: rtl/alarm_trigger_rise_edge.sv
// Single-register rising-edge detector; one-cycle pulse per low-to-high
// transition of a level input.
module alarm_trigger_rise_edge (
   input  logic uclock,
   input  logic reset,
   input  logic din,
   output logic rise
);

   logic prev;

   always_ff @(posedge uclock) begin
      if (reset) begin
         prev <= 1'b0;
      end else begin
         prev <= din;
      end
   end

   assign rise = din & ~prev;

endmodule

// File: rtl/alarm_trigger.sv
// Alarm trigger: compares wristwatch time with the alarm setting and drives
// the buzzer request, handling snooze, stop and unattended-ring timeout.
module alarm_trigger
   import alarm_trigger_pkg::*;
#(
   parameter int unsigned SNOOZE_MIN       = 5,
   parameter int unsigned RING_TIMEOUT_SEC = 60,
   parameter int unsigned MAX_SNOOZE       = 3
) (
   input  logic              uclock,
   input  logic              reset,
   input  logic              sec_tick,
   input  logic [HOUR_W-1:0] cur_hour,
   input  logic [MIN_W-1:0]  cur_min,
   input  logic [SEC_W-1:0]  cur_sec,
   input  logic [HOUR_W-1:0] alarm_hour,
   input  logic [MIN_W-1:0]  alarm_min,
   input  logic              alarm_en,
   input  logic              snooze_btn,
   input  logic              stop_btn,
   output logic              tobuzzer,
   output logic              snoozing,
   output logic [1:0]        snooze_left
);

   localparam int unsigned SNZ_LIMIT = SNOOZE_MIN * SEC_PER_MIN;
   localparam int unsigned SNZ_W     = $clog2(SNZ_LIMIT + 1);
   localparam int unsigned RING_W    = $clog2(RING_TIMEOUT_SEC + 1);

   localparam logic [SNZ_W-1:0]  SNZ_LAST  = SNZ_W'(SNZ_LIMIT);
   localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_TIMEOUT_SEC);
   localparam logic [1:0]        SNZ_MAX   = 2'(MAX_SNOOZE);

   state_t            state;
   state_t            state_next;
   logic [SNZ_W-1:0]  snz_cnt;
   logic [RING_W-1:0] ring_cnt;
   logic [SNZ_W-1:0]  snz_inc;
   logic [RING_W-1:0] ring_inc;

   logic snooze_rise;
   logic stop_rise;
   logic same_minute;
   logic alarm_match;
   logic ring_done;
   logic snz_done;

   alarm_trigger_rise_edge u_snooze_edge (
      .uclock (uclock),
      .reset  (reset),
      .din    (snooze_btn),
      .rise   (snooze_rise)
   );

   alarm_trigger_rise_edge u_stop_edge (
      .uclock (uclock),
      .reset  (reset),
      .din    (stop_btn),
      .rise   (stop_rise)
   );

   assign same_minute = (cur_hour == alarm_hour) && (cur_min == alarm_min);
   assign alarm_match = same_minute && (cur_sec == '0) && sec_tick
                        && setting_valid(alarm_hour, alarm_min);

   // Saturating increments; "done" fires on the tick that reaches the limit.
   assign ring_inc  = (ring_cnt == RING_LAST) ? ring_cnt : ring_cnt + RING_W'(1);
   assign snz_inc   = (snz_cnt == SNZ_LAST) ? snz_cnt : snz_cnt + SNZ_W'(1);
   assign ring_done = sec_tick && (ring_inc == RING_LAST);
   assign snz_done  = sec_tick && (snz_inc == SNZ_LAST);

   always_comb begin
      state_next = state;
      case (state)
         ST_DISARMED: begin
            if (alarm_en) state_next = ST_ARMED;
         end
         ST_ARMED: begin
            if (alarm_match) state_next = ST_RINGING;
         end
         ST_RINGING: begin
            if (stop_rise) begin
               state_next = ST_LOCKOUT;
            end else if (snooze_rise && (snooze_left != '0)) begin
               state_next = ST_SNOOZE;
            end else if (ring_done) begin
               state_next = ST_LOCKOUT;
            end
         end
         ST_SNOOZE: begin
            if (stop_rise) begin
               state_next = ST_LOCKOUT;
            end else if (snz_done) begin
               state_next = ST_RINGING;
            end
         end
         ST_LOCKOUT: begin
            if (!same_minute) state_next = ST_ARMED;
         end
         default: state_next = ST_DISARMED;
      endcase
      if (!alarm_en) state_next = ST_DISARMED;
   end

   always_ff @(posedge uclock) begin
      if (reset) begin
         state       <= ST_DISARMED;
         tobuzzer    <= 1'b0;
         snoozing    <= 1'b0;
         snooze_left <= SNZ_MAX;
         ring_cnt    <= '0;
         snz_cnt     <= '0;
      end else begin
         state    <= state_next;
         tobuzzer <= (state_next == ST_RINGING);
         snoozing <= (state_next == ST_SNOOZE);

         if ((state_next == ST_RINGING) && (state != ST_RINGING)) begin
            ring_cnt <= '0;
         end else if ((state == ST_RINGING) && sec_tick) begin
            ring_cnt <= ring_inc;
         end

         if ((state == ST_ARMED) && (state_next == ST_RINGING)) begin
            snooze_left <= SNZ_MAX;
         end else if ((state == ST_RINGING) && (state_next == ST_SNOOZE)) begin
            snooze_left <= snooze_left - 2'd1;
         end

         if ((state == ST_RINGING) && (state_next == ST_SNOOZE)) begin
            snz_cnt <= '0;
         end else if ((state == ST_SNOOZE) && sec_tick) begin
            snz_cnt <= snz_inc;
         end
      end
   end

endmodule
